// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master transaction engine.
//   state_t        : transaction FSM states
//   Q0..Q3         : quarter-phase encodings inside one bus slot
//   BITS_PER_BYTE  : data/address bit slots per byte
//   ACK_SLOTS      : acknowledge slots following each byte
//   calc_divider   : system clocks per SCL quarter period
package i2c_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_START,
      ST_ADDR,
      ST_ADDR_ACK,
      ST_WRITE,
      ST_WRITE_ACK,
      ST_READ,
      ST_READ_ACK,
      ST_STOP
   } state_t;

   localparam logic [1:0] Q0 = 2'd0;
   localparam logic [1:0] Q1 = 2'd1;
   localparam logic [1:0] Q2 = 2'd2;
   localparam logic [1:0] Q3 = 2'd3;

   localparam int BITS_PER_BYTE = 8;
   localparam int ACK_SLOTS     = 1;

   function automatic int calc_divider(input int clock_frequency, input int baud_rate);
      return clock_frequency / (4 * baud_rate);
   endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-period timebase for the I2C engine.
// Ports:
//   clock   : system clock
//   Reset   : synchronous active-low reset
//   restart : synchronous restart; holds the divider at count 0, phase Q0
//   tick    : high in the last clock of each quarter period
//   phase   : quarter index of the current quarter (Q0..Q3)
module i2c_quarter_tick
   import i2c_pkg::*;
#(
   parameter int Divider = 500
) (
   input  logic       clock,
   input  logic       Reset,
   input  logic       restart,
   output logic       tick,
   output logic [1:0] phase
);

   localparam int CntWidth = (Divider > 1) ? $clog2(Divider) : 1;
   localparam logic [CntWidth-1:0] TermCount = CntWidth'(Divider - 1);

   logic [CntWidth-1:0] count;

   assign tick = (count == TermCount);

   always_ff @(posedge clock) begin
      if (!Reset || restart) begin
         count <= '0;
         phase <= Q0;
      end else if (count == TermCount) begin
         count <= '0;
         phase <= phase + 2'd1;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/i2c_master_transaction_engine.sv
// Single-master I2C transaction engine: START, address + R/W, 0..MaxBytes
// data bytes (write or read), STOP. Checks every slave ACK, drives master
// ACK/NACK on reads.
// Ports:
//   clock, Reset            : system clock, synchronous active-low reset
//   Go                      : transaction request, accepted only in IDLE
//   SlaveAddress/ReadorWrite/ByteCount : transaction setup, latched on accept
//   WriteData/WriteDataLoad : next write byte, captured while WriteDataLoad=1
//   ReadData/ReadDataValid  : last received byte and its update pulse
//   SCL, SDA_in, SDA_drive_low : bus pins (SDA open-drain via drive-low)
//   Busy, Done, AckError    : transaction status
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | bus released, waiting for Go
// START     | SDA falls while SCL high
// ADDR      | 8 slots: {SlaveAddress, ReadorWrite}, MSB first
// ADDR_ACK  | SDA released, slave ACK sampled
// WRITE     | 8 slots of the current write byte, MSB first
// WRITE_ACK | SDA released, slave ACK sampled
// READ      | SDA released, 8 bits sampled MSB first
// READ_ACK  | master ACK (more bytes) or NACK (last byte)
// STOP      | SDA rises while SCL high, then Done
module i2c_master_transaction_engine
   import i2c_pkg::*;
#(
   parameter int ClockFrequency = 60000000,
   parameter int BaudRate       = 30000,
   parameter int MaxBytes       = 2,
   parameter int CountWidth     = 2
) (
   input  logic                  clock,
   input  logic                  Reset,
   input  logic                  Go,
   input  logic [6:0]            SlaveAddress,
   input  logic                  ReadorWrite,
   input  logic [CountWidth-1:0] ByteCount,
   input  logic [7:0]            WriteData,
   output logic                  WriteDataLoad,
   output logic [7:0]            ReadData,
   output logic                  ReadDataValid,
   output logic                  SCL,
   input  logic                  SDA_in,
   output logic                  SDA_drive_low,
   output logic                  Busy,
   output logic                  Done,
   output logic                  AckError
);

   localparam int Divider = calc_divider(ClockFrequency, BaudRate);
   localparam logic [CountWidth-1:0] MaxCount = CountWidth'(MaxBytes);
   localparam logic [CountWidth-1:0] OneLeft  = CountWidth'(1);
   localparam logic [2:0]            TopBit   = 3'(BITS_PER_BYTE - 1);

   state_t                state;
   state_t                nxt_state;
   logic                  tick;
   logic [1:0]            phase;
   logic [1:0]            nxt_phase;
   logic                  slot_end;
   logic                  scl_next;
   logic [7:0]            addr_byte;
   logic [7:0]            tx_byte;
   logic [7:0]            rx_shift;
   logic [2:0]            bit_idx;
   logic [2:0]            bit_idx_m1;
   logic [CountWidth-1:0] remaining;
   logic [CountWidth-1:0] count_clamped;
   logic                  is_read;
   logic                  sda_sample;

   i2c_quarter_tick #(
      .Divider (Divider)
   ) u_quarter_tick (
      .clock   (clock),
      .Reset   (Reset),
      .restart (state == ST_IDLE),
      .tick    (tick),
      .phase   (phase)
   );

   assign bit_idx_m1    = bit_idx - 3'd1;
   assign count_clamped = (ByteCount > MaxCount) ? MaxCount : ByteCount;

   // Slot sequencing and the SCL level of the quarter about to begin, so
   // that SCL is registered and changes exactly on the quarter boundary.
   always_comb begin
      slot_end  = tick && (phase == Q3);
      nxt_phase = phase + 2'd1;
      nxt_state = state;
      if (slot_end) begin
         case (state)
            ST_START:     nxt_state = ST_ADDR;
            ST_ADDR:      nxt_state = (bit_idx == 3'd0) ? ST_ADDR_ACK : ST_ADDR;
            ST_ADDR_ACK: begin
               if (sda_sample || (remaining == '0)) nxt_state = ST_STOP;
               else if (is_read)                    nxt_state = ST_READ;
               else                                 nxt_state = ST_WRITE;
            end
            ST_WRITE:     nxt_state = (bit_idx == 3'd0) ? ST_WRITE_ACK : ST_WRITE;
            ST_WRITE_ACK: nxt_state = (sda_sample || (remaining == OneLeft)) ? ST_STOP : ST_WRITE;
            ST_READ:      nxt_state = (bit_idx == 3'd0) ? ST_READ_ACK : ST_READ;
            ST_READ_ACK:  nxt_state = (remaining == OneLeft) ? ST_STOP : ST_READ;
            ST_STOP:      nxt_state = ST_IDLE;
            default:      nxt_state = ST_IDLE;
         endcase
      end

      scl_next = 1'b1;
      case (nxt_state)
         ST_IDLE:  scl_next = 1'b1;
         ST_START: scl_next = (nxt_phase != Q3);
         ST_STOP:  scl_next = (nxt_phase != Q0);
         default:  scl_next = (nxt_phase == Q1) || (nxt_phase == Q2);
      endcase
   end

   always_ff @(posedge clock) begin
      if (!Reset) begin
         state         <= ST_IDLE;
         SCL           <= 1'b1;
         SDA_drive_low <= 1'b0;
         Busy          <= 1'b0;
         Done          <= 1'b0;
         AckError      <= 1'b0;
         ReadData      <= 8'h00;
         ReadDataValid <= 1'b0;
         WriteDataLoad <= 1'b0;
         addr_byte     <= 8'h00;
         tx_byte       <= 8'h00;
         rx_shift      <= 8'h00;
         bit_idx       <= 3'd0;
         remaining     <= '0;
         is_read       <= 1'b0;
         sda_sample    <= 1'b1;
      end else begin
         Done          <= 1'b0;
         ReadDataValid <= 1'b0;
         WriteDataLoad <= 1'b0;

         // Write byte arrives one clock into q0 of bit 7; SCL is low then.
         if (WriteDataLoad) begin
            tx_byte       <= WriteData;
            SDA_drive_low <= ~WriteData[7];
         end

         if (state == ST_IDLE) begin
            // Done blocks acceptance so at least one idle cycle separates transactions.
            if (Go && !Done) begin
               addr_byte <= {SlaveAddress, ReadorWrite};
               is_read   <= ReadorWrite;
               remaining <= count_clamped;
               Busy      <= 1'b1;
               AckError  <= 1'b0;
               state     <= ST_START;
            end
         end else if (tick) begin
            SCL <= scl_next;

            if (phase == Q2) begin
               sda_sample <= SDA_in;
               if (state == ST_READ) rx_shift <= {rx_shift[6:0], SDA_in};
            end

            if ((state == ST_START) && (phase == Q0)) SDA_drive_low <= 1'b1;
            if ((state == ST_STOP)  && (phase == Q2)) SDA_drive_low <= 1'b0;

            if (slot_end) begin
               state <= nxt_state;
               case (state)
                  ST_START: begin
                     bit_idx       <= TopBit;
                     SDA_drive_low <= ~addr_byte[7];
                  end
                  ST_ADDR: begin
                     if (bit_idx != 3'd0) begin
                        bit_idx       <= bit_idx_m1;
                        SDA_drive_low <= ~addr_byte[bit_idx_m1];
                     end else begin
                        SDA_drive_low <= 1'b0;
                     end
                  end
                  ST_ADDR_ACK: begin
                     if (sda_sample) AckError <= 1'b1;
                     bit_idx <= TopBit;
                     if (!sda_sample && (remaining != '0) && !is_read) WriteDataLoad <= 1'b1;
                  end
                  ST_WRITE: begin
                     if (bit_idx != 3'd0) begin
                        bit_idx       <= bit_idx_m1;
                        SDA_drive_low <= ~tx_byte[bit_idx_m1];
                     end else begin
                        SDA_drive_low <= 1'b0;
                     end
                  end
                  ST_WRITE_ACK: begin
                     if (sda_sample) begin
                        AckError <= 1'b1;
                     end else begin
                        remaining <= remaining - 1'b1;
                        if (remaining != OneLeft) begin
                           bit_idx       <= TopBit;
                           WriteDataLoad <= 1'b1;
                        end
                     end
                  end
                  ST_READ: begin
                     if (bit_idx != 3'd0) begin
                        bit_idx <= bit_idx_m1;
                     end else begin
                        ReadData      <= rx_shift;
                        ReadDataValid <= 1'b1;
                        // ACK while more bytes follow, NACK the last one.
                        SDA_drive_low <= (remaining != OneLeft);
                     end
                  end
                  ST_READ_ACK: begin
                     remaining     <= remaining - 1'b1;
                     bit_idx       <= TopBit;
                     SDA_drive_low <= 1'b0;
                  end
                  ST_STOP: begin
                     Busy <= 1'b0;
                     Done <= 1'b1;
                  end
                  default: ;
               endcase
               // STOP opens with SDA held low under a low SCL.
               if (nxt_state == ST_STOP) SDA_drive_low <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_i2c_master_transaction_engine.sv
module tb_i2c_master_transaction_engine;

   localparam int CF = 400;
   localparam int BR = 25;
   localparam int MB = 2;
   localparam int CW = 2;

   logic          clock = 1'b0;
   logic          Reset = 1'b0;
   logic          Go = 1'b0;
   logic [6:0]    SlaveAddress = 7'h00;
   logic          ReadorWrite = 1'b0;
   logic [CW-1:0] ByteCount = '0;
   logic [7:0]    WriteData = 8'h00;
   logic          WriteDataLoad;
   logic [7:0]    ReadData;
   logic          ReadDataValid;
   logic          SCL;
   logic          SDA_in;
   logic          SDA_drive_low;
   logic          Busy;
   logic          Done;
   logic          AckError;

   i2c_master_transaction_engine #(
      .ClockFrequency (CF),
      .BaudRate       (BR),
      .MaxBytes       (MB),
      .CountWidth     (CW)
   ) dut (
      .clock         (clock),
      .Reset         (Reset),
      .Go            (Go),
      .SlaveAddress  (SlaveAddress),
      .ReadorWrite   (ReadorWrite),
      .ByteCount     (ByteCount),
      .WriteData     (WriteData),
      .WriteDataLoad (WriteDataLoad),
      .ReadData      (ReadData),
      .ReadDataValid (ReadDataValid),
      .SCL           (SCL),
      .SDA_in        (SDA_in),
      .SDA_drive_low (SDA_drive_low),
      .Busy          (Busy),
      .Done          (Done),
      .AckError      (AckError)
   );

   always #5 clock = ~clock;

   // open-drain bus: slave and master both can pull low
   logic slave_sda = 1'b1;
   assign SDA_in = SDA_drive_low ? 1'b0 : slave_sda;

   int   n_tests = 0;
   int   n_fail  = 0;

   logic slave_present = 1'b1;
   logic [7:0] rd_bytes [4];
   logic [7:0] wr_tbl [4];
   logic [7:0] rd_seen [4];
   logic bits [64];
   int   bitcnt = -1;
   logic prev_scl = 1'b1;
   logic prev_sda = 1'b1;
   int   busy_cnt = 0;
   int   done_cnt = 0;
   int   rdv_cnt = 0;
   int   wdl_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic slave_bit(input int k);
      int pos;
      int idx;
      if (!slave_present || k < 8) return 1'b1;
      if (k == 8) return 1'b0;
      pos = (k - 9) % 9;
      idx = (k - 9) / 9;
      if (bits[7] == 1'b0) return (pos == 8) ? 1'b0 : 1'b1;
      if (pos == 8 || idx > 3) return 1'b1;
      return rd_bytes[idx][7 - pos];
   endfunction

   function automatic logic [7:0] get_byte(input int s);
      logic [7:0] b;
      b = 8'h00;
      for (int i = 0; i < 8; i++) b = {b[6:0], bits[s + i]};
      return b;
   endfunction

   // bus monitor, slave model and status counters
   always @(negedge clock) begin
      logic bus;
      bus = SDA_in;
      if (prev_scl && SCL && prev_sda && !bus) begin
         bitcnt = -1;
      end else if (!prev_scl && SCL) begin
         if (bitcnt >= 0 && bitcnt < 64) bits[bitcnt] = bus;
      end else if (prev_scl && !SCL) begin
         bitcnt++;
         slave_sda = slave_bit(bitcnt);
      end
      prev_scl = SCL;
      prev_sda = bus;
      if (Busy) busy_cnt++;
      if (Done) done_cnt++;
      if (ReadDataValid) begin
         if (rdv_cnt < 4) rd_seen[rdv_cnt] = ReadData;
         rdv_cnt++;
      end
      if (WriteDataLoad) wdl_cnt++;
      else if (wdl_cnt < 4) WriteData = wr_tbl[wdl_cnt];
   end

   task automatic clear_counts();
      busy_cnt = 0;
      done_cnt = 0;
      rdv_cnt  = 0;
      wdl_cnt  = 0;
      slave_sda = 1'b1;
      for (int i = 0; i < 64; i++) bits[i] = 1'b1;
   endtask

   task automatic run_txn(input logic [6:0] a, input logic rw, input logic [CW-1:0] n,
                          input logic present, input logic poke_go);
      int cyc;
      clear_counts();
      slave_present = present;
      @(posedge clock); #1;
      SlaveAddress = a;
      ReadorWrite  = rw;
      ByteCount    = n;
      Go           = 1'b1;
      @(posedge clock); #1;
      Go = 1'b0;
      cyc = 0;
      while (done_cnt == 0 && cyc < 3000) begin
         @(posedge clock); #1;
         cyc++;
         Go = (poke_go && cyc == 100);
      end
      Go = 1'b0;
      check("done_seen", 32'(done_cnt > 0), 32'd1);
      repeat (4) @(posedge clock);
      #1;
   endtask

   initial begin
      int t_done;
      int t_busy;
      int cyc;

      for (int i = 0; i < 4; i++) begin
         wr_tbl[i]   = 8'h00;
         rd_bytes[i] = 8'h00;
         rd_seen[i]  = 8'h00;
      end
      repeat (3) @(posedge clock);
      #1;
      check("rst_scl",  32'(SCL), 32'd1);
      check("rst_sda",  32'(SDA_drive_low), 32'd0);
      check("rst_busy", 32'(Busy), 32'd0);
      check("rst_done", 32'(Done), 32'd0);
      check("rst_ackerr", 32'(AckError), 32'd0);
      check("rst_rdata", 32'(ReadData), 32'h00);
      check("rst_flags", 32'({ReadDataValid, WriteDataLoad}), 32'd0);
      Reset = 1'b1;
      repeat (2) @(posedge clock);
      #1;

      // write one byte, slave ACKs; Go pulse mid-transaction is ignored
      wr_tbl[0] = 8'hA5;
      run_txn(7'h48, 1'b0, 2'd1, 1'b1, 1'b1);
      check("wr_addr", 32'(get_byte(0)), 32'h90);
      check("wr_aack", 32'(bits[8]), 32'd0);
      check("wr_data", 32'(get_byte(9)), 32'hA5);
      check("wr_dack", 32'(bits[17]), 32'd0);
      check("wr_loads", 32'(wdl_cnt), 32'd1);
      check("wr_ackerr", 32'(AckError), 32'd0);
      check("wr_busy", 32'(busy_cnt), 32'd320);
      check("wr_done", 32'(done_cnt), 32'd1);

      // read two bytes
      rd_bytes[0] = 8'h19;
      rd_bytes[1] = 8'h60;
      run_txn(7'h48, 1'b1, 2'd2, 1'b1, 1'b0);
      check("rd_addr", 32'(get_byte(0)), 32'h91);
      check("rd_valid_cnt", 32'(rdv_cnt), 32'd2);
      check("rd_byte0", 32'(rd_seen[0]), 32'h19);
      check("rd_byte1", 32'(rd_seen[1]), 32'h60);
      check("rd_mack", 32'(bits[17]), 32'd0);
      check("rd_mnack", 32'(bits[26]), 32'd1);
      check("rd_busy", 32'(busy_cnt), 32'd464);
      check("rd_hold", 32'(ReadData), 32'h60);
      check("rd_ackerr", 32'(AckError), 32'd0);

      // address NACK
      run_txn(7'h48, 1'b0, 2'd2, 1'b0, 1'b0);
      check("nack_ackerr", 32'(AckError), 32'd1);
      check("nack_aack", 32'(bits[8]), 32'd1);
      check("nack_loads", 32'(wdl_cnt), 32'd0);
      check("nack_busy", 32'(busy_cnt), 32'd176);
      check("nack_done", 32'(done_cnt), 32'd1);

      // probe, zero bytes; AckError clears on accept
      run_txn(7'h48, 1'b0, 2'd0, 1'b1, 1'b0);
      check("probe_busy", 32'(busy_cnt), 32'd176);
      check("probe_loads", 32'(wdl_cnt), 32'd0);
      check("probe_ackerr", 32'(AckError), 32'd0);

      // ByteCount 3 clamps to 2
      wr_tbl[0] = 8'hA5;
      wr_tbl[1] = 8'h3C;
      run_txn(7'h48, 1'b0, 2'd3, 1'b1, 1'b0);
      check("clamp_busy", 32'(busy_cnt), 32'd464);
      check("clamp_loads", 32'(wdl_cnt), 32'd2);
      check("clamp_b0", 32'(get_byte(9)), 32'hA5);
      check("clamp_b1", 32'(get_byte(18)), 32'h3C);

      // reset in the middle of ADDR
      clear_counts();
      slave_present = 1'b1;
      @(posedge clock); #1;
      SlaveAddress = 7'h48;
      ReadorWrite  = 1'b1;
      ByteCount    = 2'd1;
      Go           = 1'b1;
      @(posedge clock); #1;
      Go = 1'b0;
      repeat (40) @(posedge clock);
      #1;
      check("mid_busy", 32'(Busy), 32'd1);
      Reset = 1'b0;
      @(posedge clock); #1;
      check("abort_scl", 32'(SCL), 32'd1);
      check("abort_sda", 32'(SDA_drive_low), 32'd0);
      check("abort_busy", 32'(Busy), 32'd0);
      check("abort_rdata", 32'(ReadData), 32'h00);
      Reset = 1'b1;
      repeat (200) @(posedge clock);
      #1;
      check("abort_nodone", 32'(done_cnt), 32'd0);
      check("abort_idle", 32'(Busy), 32'd0);

      // Go held high across Done
      clear_counts();
      SlaveAddress = 7'h48;
      ReadorWrite  = 1'b0;
      ByteCount    = 2'd0;
      Go           = 1'b1;
      t_done = -1;
      t_busy = -1;
      cyc = 0;
      while (t_busy < 0 && cyc < 1000) begin
         @(posedge clock); #1;
         cyc++;
         if (Done && t_done < 0) t_done = cyc;
         if (t_done >= 0 && cyc > t_done && Busy) t_busy = cyc;
      end
      Go = 1'b0;
      check("held_restart", 32'(t_busy >= 0), 32'd1);
      check("held_gap", 32'((t_busy - t_done) >= 2), 32'd1);
      cyc = 0;
      while (done_cnt < 2 && cyc < 1000) begin
         @(posedge clock); #1;
         cyc++;
      end
      check("held_done2", 32'(done_cnt), 32'd2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
